nf_parity_rx: RTL

- SPI-side serial frame receiver and parity checker.
- Frame format: M data bits, MSB first, followed by one parity bit.
- Parity rule: the parity bit equals the XOR of the data bits (1 when the count of ones is odd), so data plus parity always holds an even number of ones.
- Position: sits behind the SCLK/CS synchronizers in the SPI execution unit. Delivers checked words to the core over a valid/ready handshake.

---
 rtl/nf_spi_pkg.sv | 14 +
 rtl/nf_rx_shift.sv | 34 +++
 rtl/nf_parity_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nf_spi_pkg.sv
// Shared types and constants for the SPI-side
// serial receive path.
package nf_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    END
  } state_t;

  localparam logic PAR_ODD_ONES = 1'b1;

endpackage

// File: rtl/nf_rx_shift.sv
// MSB-first deserializer with a running XOR
// of every bit shifted in since the last clear.
module nf_rx_shift #(
  parameter int M = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [M-1:0] o_word,
  output logic         o_par
);

  logic [M-1:0] r_word;
  logic         r_par;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_par  <= 1'b0;
    end else if (i_clr) begin
      r_word <= '0;
      r_par  <= 1'b0;
    end else if (i_en) begin
      r_word <= {r_word[M-2:0], i_bit};
      r_par  <= r_par ^ i_bit;
    end
  end

  assign o_word = r_word;
  assign o_par  = r_par;

endmodule

// File: rtl/nf_parity_rx.sv
// SPI frame receiver: M data bits MSB first plus
// an even-parity bit, delivered over valid/ready.
module nf_parity_rx
  import nf_spi_pkg::*;
#(
  parameter int M  = 4,
  parameter int CW = $clog2(M)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cs_n,
  input  logic         i_sclk_stb,
  input  logic         i_mosi,
  input  logic         i_ready,
  output logic [M-1:0] o_data,
  output logic         o_valid,
  output logic         o_par_err,
  output logic         o_frame_err,
  output logic         o_overrun
);

  state_t       r_state;
  state_t       w_next;
  logic         r_cs_n_q;
  logic [CW-1:0] r_cnt;
  logic [M-1:0] r_data;
  logic         r_valid;
  logic         r_perr;
  logic         r_ferr;
  logic         r_ovr;

  logic         w_start;
  logic         w_clr;
  logic         w_en;
  logic         w_abort;
  logic         w_done;
  logic         w_load;
  logic         w_ovr;
  logic         w_err;
  logic         w_exp;
  logic [M-1:0] w_word;
  logic         w_par;

  assign w_start = ~i_cs_n & r_cs_n_q;

  nf_rx_shift #(.M(M)) u_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_bit   (i_mosi),
    .o_word  (w_word),
    .o_par   (w_par)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cs_n_q <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_cs_n_q <= i_cs_n;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_en    = 1'b0;
    w_abort = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = SHIFT;
          w_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (i_cs_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (i_sclk_stb) begin
          w_en = 1'b1;
          if (r_cnt == CW'(M-1))
            w_next = PAR;
        end
      end
      PAR: begin
        if (i_cs_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (i_sclk_stb) begin
          w_done = 1'b1;
          w_next = END;
        end
      end
      END: begin
        if (i_cs_n)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Expected parity bit derived from the running XOR
  assign w_exp  = w_par ? PAR_ODD_ONES : ~PAR_ODD_ONES;
  assign w_err  = i_mosi ^ w_exp;
  assign w_load = w_done & (~r_valid | i_ready);
  assign w_ovr  = w_done & r_valid & ~i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (w_clr)
      r_cnt <= '0;
    else if (w_en)
      r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_abort;
      r_ovr  <= w_ovr;
      if (w_load) begin
        r_data  <= w_word;
        r_perr  <= w_err;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_par_err   = r_perr;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;

endmodule
